// File: rtl/seg_scan_mux.sv
// Eight-digit hex scan multiplexer feeding one shared 7-segment decoder.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux #(
   parameter int DIV = 100000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] DATA,
   input  logic [7:0]  EN_MASK,
   output logic [3:0]  DIGIT,
   output logic [7:0]  AN,
   output logic        BLANK,
   output logic        FRAME
);

   localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt_q,   cnt_d;
   logic [2:0]    idx_q,   idx_d;
   logic [31:0]   data_q,  data_d;
   logic [7:0]    mask_q,  mask_d;
   logic [3:0]    digit_q, digit_d;
   logic [7:0]    an_q,    an_d;
   logic          blank_q, blank_d;
   logic          frame_q, frame_d;

   logic          tick;
   logic          load;
   logic [2:0]    nxt;
   logic [31:0]   cur_data;
   logic [7:0]    cur_mask;
   logic          lit;
   logic [2:0]    high_idx;

   assign tick = (cnt_q == CNT_MAX);
   assign load = tick && (idx_q == 3'd7);
   assign nxt  = idx_q + 3'd1;

   // On a frame-load tick the fresh inputs are shown at once, so the
   // shadow registers never add a frame of latency.
   assign cur_data = load ? DATA    : data_q;
   assign cur_mask = load ? EN_MASK : mask_q;

   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
      high_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (cur_data[4*i +: 4] != 4'd0) high_idx = 3'(i);
      end
   end

`ifdef SEG_SCAN_LZB_EN
   assign lit = cur_mask[nxt] && (nxt <= high_idx);
`else
   assign lit = cur_mask[nxt];
`endif

   always_comb begin
      cnt_d   = tick ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      data_d  = data_q;
      mask_d  = mask_q;
      digit_d = digit_q;
      an_d    = an_q;
      blank_d = blank_q;
      frame_d = 1'b0;
      if (tick) begin
         idx_d   = nxt;
         digit_d = cur_data[4*nxt +: 4];
         blank_d = ~lit;
         an_d    = lit ? ~(8'b1 << nxt) : 8'hFF;
         frame_d = (nxt == 3'd0);
      end
      if (load) begin
         data_d = DATA;
         mask_d = EN_MASK;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q   <= '0;
         idx_q   <= 3'd7;
         data_q  <= '0;
         mask_q  <= '0;
         digit_q <= 4'd0;
         an_q    <= 8'hFF;
         blank_q <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         digit_q <= digit_d;
         an_q    <= an_d;
         blank_q <= blank_d;
         frame_q <= frame_d;
      end
   end

   assign DIGIT = digit_q;
   assign AN    = an_q;
   assign BLANK = blank_q;
   assign FRAME = frame_q;

endmodule
